// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace stream arbiter.
package trdb_pkg;

  typedef enum logic [2:0] {
    ARB,
    TS_LO,
    TS_HI,
    FLUSH_WAIT,
    FLUSH_DONE
  } trdb_arb_state_e;

  typedef enum logic [1:0] {
    SRC_PKT   = 2'd0,
    SRC_SW    = 2'd1,
    SRC_TIME  = 2'd2,
    SRC_FLUSH = 2'd3
  } trdb_arb_src_e;

  localparam logic [31:0] TRDB_FLUSH_MARKER = 32'hF1A5_0000;

endpackage

// File: rtl/trdb_arb_out_reg.sv
// One-deep valid/ready output register; slot_free tells the arbiter it may load this cycle.
module trdb_arb_out_reg
  import trdb_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_en,
  input  logic [31:0]   load_word,
  input  trdb_arb_src_e load_src,
  input  logic          ready,
  output logic          valid,
  output logic [31:0]   word,
  output trdb_arb_src_e src,
  output logic          slot_free
);

  // The slot frees up either when empty or when the current word leaves this cycle
  assign slot_free = ~valid | ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= 1'b0;
      word  <= '0;
      src   <= SRC_PKT;
    end else if (load_en) begin
      valid <= 1'b1;
      word  <= load_word;
      src   <= load_src;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trdb_stream_arbiter.sv
// Shares the 32-bit trace stream between packet, software and timestamp words and runs the flush handshake.
// Optional statistics counters are built when TRDB_ARB_STATS_EN is defined.
module trdb_stream_arbiter
  import trdb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [31:0]          pkt_word_i,
  input  logic                 pkt_valid_i,
  output logic                 pkt_grant_o,
  input  logic [31:0]          sw_word_i,
  input  logic                 sw_valid_i,
  input  logic                 sw_time_i,
  output logic                 sw_grant_o,
  input  logic [63:0]          timer_i,
  input  logic                 flush_stream_i,
  output logic                 flush_confirm_o,
  output logic [31:0]          out_word_o,
  output logic [1:0]           out_src_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] stat_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] stat_sw_cnt_o,
  output logic [CNT_WIDTH-1:0] stat_stall_cnt_o
);

  localparam int unsigned    SCW        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam bit             STARVE_EN  = (STARVE_LIMIT != 0);

  trdb_arb_state_e state_q, state_d;
  logic [63:0]     ts_q;
  logic [SCW-1:0]  starve_cnt_q;
  logic            starve_hit;

  logic            load_en;
  logic [31:0]     load_word;
  trdb_arb_src_e   load_src;
  logic            pkt_grant, sw_grant, confirm;

  logic            valid_q, slot_free;
  logic [31:0]     word_q;
  trdb_arb_src_e   src_q;

  assign starve_hit = STARVE_EN && (starve_cnt_q == STARVE_MAX) && sw_valid_i && !flush_stream_i;

  trdb_arb_out_reg u_out_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_en   (load_en),
    .load_word (load_word),
    .load_src  (load_src),
    .ready     (out_ready_i),
    .valid     (valid_q),
    .word      (word_q),
    .src       (src_q),
    .slot_free (slot_free)
  );

  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    load_word = '0;
    load_src  = SRC_PKT;
    pkt_grant = 1'b0;
    sw_grant  = 1'b0;
    confirm   = 1'b0;
    case (state_q)
      ARB: begin
        if (slot_free && enable_i) begin
          if (starve_hit || (!pkt_valid_i && sw_valid_i && !flush_stream_i)) begin
            sw_grant  = 1'b1;
            load_en   = 1'b1;
            load_word = sw_word_i;
            load_src  = SRC_SW;
            if (sw_time_i) state_d = TS_LO;
          end else if (pkt_valid_i) begin
            pkt_grant = 1'b1;
            load_en   = 1'b1;
            load_word = pkt_word_i;
            load_src  = SRC_PKT;
          end else if (flush_stream_i) begin
            load_en   = 1'b1;
            load_word = TRDB_FLUSH_MARKER;
            load_src  = SRC_FLUSH;
            state_d   = FLUSH_WAIT;
          end
        end
      end
      // Timestamp halves go out back to back, ignoring enable and flush
      TS_LO: begin
        if (slot_free) begin
          load_en   = 1'b1;
          load_word = ts_q[31:0];
          load_src  = SRC_TIME;
          state_d   = TS_HI;
        end
      end
      TS_HI: begin
        if (slot_free) begin
          load_en   = 1'b1;
          load_word = ts_q[63:32];
          load_src  = SRC_TIME;
          state_d   = ARB;
        end
      end
      FLUSH_WAIT: begin
        if (valid_q && out_ready_i) begin
          confirm = 1'b1;
          state_d = FLUSH_DONE;
        end
      end
      FLUSH_DONE: state_d = ARB;
      default:    state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      if (sw_grant && sw_time_i) ts_q <= timer_i;
    end
  end

  // Counts packet grants that overtook a waiting software word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (sw_grant || !sw_valid_i) begin
      starve_cnt_q <= '0;
    end else if (pkt_grant && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end

  // Reset forces every output low immediately, not only after the clock edge
  assign pkt_grant_o     = pkt_grant & ~rst_i;
  assign sw_grant_o      = sw_grant & ~rst_i;
  assign flush_confirm_o = confirm & ~rst_i;
  assign out_valid_o     = valid_q & ~rst_i;
  assign out_word_o      = rst_i ? 32'd0 : word_q;
  assign out_src_o       = rst_i ? 2'd0 : src_q;

`ifdef TRDB_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_cnt_q, sw_cnt_q, stall_cnt_q;
  logic                 handshake;

  assign handshake = valid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q   <= '0;
      sw_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (handshake && (src_q == SRC_PKT) && !(&pkt_cnt_q)) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (handshake && (src_q == SRC_SW) && !(&sw_cnt_q)) sw_cnt_q <= sw_cnt_q + 1'b1;
      if (valid_q && !out_ready_i && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stat_pkt_cnt_o   = rst_i ? '0 : pkt_cnt_q;
  assign stat_sw_cnt_o    = rst_i ? '0 : sw_cnt_q;
  assign stat_stall_cnt_o = rst_i ? '0 : stall_cnt_q;
`else
  assign stat_pkt_cnt_o   = '0;
  assign stat_sw_cnt_o    = '0;
  assign stat_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trdb_stream_arbiter.sv
// Directed self-checking bench for trdb_stream_arbiter: starvation, timestamps, stalls, flush, reset and enable.
module tb_trdb_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] pkt_word_i;
  logic        pkt_valid_i;
  logic        pkt_grant_o;
  logic [31:0] sw_word_i;
  logic        sw_valid_i;
  logic        sw_time_i;
  logic        sw_grant_o;
  logic [63:0] timer_i;
  logic        flush_stream_i;
  logic        flush_confirm_o;
  logic [31:0] out_word_o;
  logic [1:0]  out_src_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] stat_pkt_cnt_o;
  logic [15:0] stat_sw_cnt_o;
  logic [15:0] stat_stall_cnt_o;

  always #5 clk = ~clk;

  trdb_stream_arbiter #(.STARVE_LIMIT(8), .CNT_WIDTH(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .pkt_word_i       (pkt_word_i),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_grant_o      (pkt_grant_o),
    .sw_word_i        (sw_word_i),
    .sw_valid_i       (sw_valid_i),
    .sw_time_i        (sw_time_i),
    .sw_grant_o       (sw_grant_o),
    .timer_i          (timer_i),
    .flush_stream_i   (flush_stream_i),
    .flush_confirm_o  (flush_confirm_o),
    .out_word_o       (out_word_o),
    .out_src_o        (out_src_o),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .stat_pkt_cnt_o   (stat_pkt_cnt_o),
    .stat_sw_cnt_o    (stat_sw_cnt_o),
    .stat_stall_cnt_o (stat_stall_cnt_o)
  );

  int          checks = 0;
  int          failures = 0;
  logic [33:0] emitted[$];
  int          pkt_total, pkt_sent;
  logic [31:0] pkt_base;
  logic [32:0] sw_mem[16];
  int          sw_wr, sw_rd;
  logic        last_pg, last_sg;
  int          confirm_cnt = 0;
  int          sw_grant_cnt = 0;
  int          both_cnt = 0;
  int          base_a, base_b;
  logic [15:0] stall_before;
  logic [63:0] exp_v;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents the head of the modelled packet and software FIFOs
  task automatic applyStimulus();
    pkt_valid_i = (pkt_sent < pkt_total);
    pkt_word_i  = pkt_base + 32'(pkt_sent);
    sw_valid_i  = (sw_rd < sw_wr);
    sw_word_i   = sw_valid_i ? sw_mem[sw_rd][31:0] : 32'd0;
    sw_time_i   = sw_valid_i ? sw_mem[sw_rd][32] : 1'b0;
  endtask

  // Samples at the falling edge, then advances the FIFOs just after the rising edge
  task automatic tick();
    @(negedge clk);
    last_pg = pkt_grant_o;
    last_sg = sw_grant_o;
    if (out_valid_o && out_ready_i) emitted.push_back({out_src_o, out_word_o});
    if (flush_confirm_o) confirm_cnt++;
    if (sw_grant_o) sw_grant_cnt++;
    if (pkt_grant_o && sw_grant_o) both_cnt++;
    @(posedge clk);
    #1;
    if (last_pg) pkt_sent++;
    if (last_sg) sw_rd++;
    applyStimulus();
  endtask

  function automatic logic [63:0] emittedAt(input int idx);
    if (idx < emitted.size()) return 64'(emitted[idx]);
    return '1;
  endfunction

  function automatic logic [63:0] ent(input logic [1:0] s, input logic [31:0] w);
    return {30'd0, s, w};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_i = 1'b1;
    enable_i = 1'b1;
    out_ready_i = 1'b1;
    flush_stream_i = 1'b0;
    timer_i = 64'd0;
    pkt_base = 32'h1111_0000;
    pkt_sent = 0;
    pkt_total = 5;
    sw_rd = 0;
    sw_wr = 1;
    sw_mem[0] = {1'b0, 32'h2222_0000};
    applyStimulus();

    // Reset with sources valid: everything reads zero
    tick();
    tick();
    checkOutput("rst_pkt_grant", last_pg, 0);
    checkOutput("rst_sw_grant", last_sg, 0);
    checkOutput("rst_out_valid", out_valid_o, 0);
    checkOutput("rst_out_word", out_word_o, 0);
    checkOutput("rst_out_src", out_src_o, 0);
    checkOutput("rst_confirm", flush_confirm_o, 0);
    checkOutput("rst_stats", {stat_pkt_cnt_o, stat_sw_cnt_o, stat_stall_cnt_o}, 0);

    // Starvation: 8 packets then 1 software word, three times
    rst_i = 1'b0;
    emitted.delete();
    pkt_base = 32'hA000_0000;
    pkt_sent = 0;
    pkt_total = 24;
    sw_rd = 0;
    sw_wr = 3;
    for (int k = 0; k < 3; k++) sw_mem[k] = {1'b0, 32'h5000_0000 + 32'(k)};
    applyStimulus();
    tick();
    checkOutput("latency_valid", out_valid_o, 1);
    checkOutput("latency_word", out_word_o, 32'hA000_0000);
    for (int c = 0; c < 200 && emitted.size() < 27; c++) tick();
    tick();
    tick();
    checkOutput("starve_len", emitted.size(), 27);
    for (int i = 0; i < 27; i++) begin
      if (i % 9 == 8) exp_v = ent(2'd1, 32'h5000_0000 + 32'(i / 9));
      else exp_v = ent(2'd0, 32'hA000_0000 + 32'((i / 9) * 8 + (i % 9)));
      checkOutput($sformatf("starve_seq[%0d]", i), emittedAt(i), exp_v);
    end
    checkOutput("starve_idle", out_valid_o, 0);

    // Timestamp after a software word; timer changes after capture
    emitted.delete();
    pkt_base = 32'hB000_0000;
    pkt_sent = 0;
    pkt_total = 0;
    sw_rd = 0;
    sw_wr = 1;
    sw_mem[0] = {1'b1, 32'hDEAD_BEEF};
    timer_i = 64'h0000_0001_0000_0002;
    base_a = sw_grant_cnt;
    applyStimulus();
    tick();
    timer_i = 64'hFFFF_FFFF_FFFF_FFFF;
    pkt_total = 2;
    applyStimulus();
    for (int c = 0; c < 50 && emitted.size() < 5; c++) tick();
    tick();
    checkOutput("ts_len", emitted.size(), 5);
    checkOutput("ts_sw", emittedAt(0), ent(2'd1, 32'hDEAD_BEEF));
    checkOutput("ts_lo", emittedAt(1), ent(2'd2, 32'h0000_0002));
    checkOutput("ts_hi", emittedAt(2), ent(2'd2, 32'h0000_0001));
    checkOutput("ts_pkt0", emittedAt(3), ent(2'd0, 32'hB000_0000));
    checkOutput("ts_pkt1", emittedAt(4), ent(2'd0, 32'hB000_0001));
    checkOutput("ts_sw_grants", sw_grant_cnt - base_a, 1);

    // Sink stall for 5 cycles with a word loaded
    emitted.delete();
    pkt_base = 32'hC000_0000;
    pkt_sent = 0;
    pkt_total = 3;
    stall_before = stat_stall_cnt_o;
    applyStimulus();
    tick();
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("stall_word[%0d]", k), out_word_o, 32'hC000_0000);
      checkOutput($sformatf("stall_grant[%0d]", k), last_pg, 0);
      checkOutput($sformatf("stall_valid[%0d]", k), out_valid_o, 1);
    end
`ifdef TRDB_ARB_STATS_EN
    checkOutput("stall_stat", stat_stall_cnt_o - stall_before, 5);
`else
    checkOutput("stall_stat", stat_stall_cnt_o, 0);
`endif
    out_ready_i = 1'b1;
    for (int c = 0; c < 50 && emitted.size() < 3; c++) tick();
    tick();
    checkOutput("stall_len", emitted.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("stall_seq[%0d]", i), emittedAt(i), ent(2'd0, 32'hC000_0000 + 32'(i)));

    // Flush with 3 packets pending and a software word waiting
    emitted.delete();
    pkt_base = 32'hD000_0000;
    pkt_sent = 0;
    pkt_total = 3;
    sw_rd = 0;
    sw_wr = 1;
    sw_mem[0] = {1'b0, 32'h5555_AAAA};
    flush_stream_i = 1'b1;
    base_a = sw_grant_cnt;
    base_b = confirm_cnt;
    applyStimulus();
    for (int c = 0; c < 50 && confirm_cnt == base_b; c++) tick();
    flush_stream_i = 1'b0;
    checkOutput("flush_confirm", confirm_cnt - base_b, 1);
    checkOutput("flush_no_sw", sw_grant_cnt - base_a, 0);
    checkOutput("flush_len", emitted.size(), 4);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("flush_pkt[%0d]", i), emittedAt(i), ent(2'd0, 32'hD000_0000 + 32'(i)));
    checkOutput("flush_marker", emittedAt(3), ent(2'd3, 32'hF1A5_0000));
    for (int c = 0; c < 50 && emitted.size() < 5; c++) tick();
    tick();
    tick();
    checkOutput("flush_confirm_once", confirm_cnt - base_b, 1);
    checkOutput("flush_sw_after", emittedAt(4), ent(2'd1, 32'h5555_AAAA));

    // Reset while the high timestamp word is pending
    emitted.delete();
    pkt_sent = 0;
    pkt_total = 0;
    sw_rd = 0;
    sw_wr = 1;
    sw_mem[0] = {1'b1, 32'h1234_5678};
    timer_i = 64'hAAAA_BBBB_CCCC_DDDD;
    applyStimulus();
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    checkOutput("rst_mid_valid_gated", out_valid_o, 0);
    tick();
    rst_i = 1'b0;
    pkt_base = 32'hE000_0000;
    pkt_sent = 0;
    pkt_total = 1;
    applyStimulus();
    #1;
    checkOutput("rst_mid_valid", out_valid_o, 0);
    tick();
    checkOutput("rst_mid_arb_grant", last_pg, 1);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("rst_mid_len", emitted.size(), 2);
    checkOutput("rst_mid_sw", emittedAt(0), ent(2'd1, 32'h1234_5678));
    checkOutput("rst_mid_pkt", emittedAt(1), ent(2'd0, 32'hE000_0000));

    // Enable low with all sources valid
    emitted.delete();
    pkt_base = 32'hF000_0000;
    pkt_sent = 0;
    pkt_total = 4;
    sw_rd = 0;
    sw_wr = 1;
    sw_mem[0] = {1'b0, 32'h0BAD_F00D};
    applyStimulus();
    tick();
    enable_i = 1'b0;
    tick();
    checkOutput("en_drain_pg", last_pg, 0);
    checkOutput("en_drain_sg", last_sg, 0);
    checkOutput("en_drain_valid", out_valid_o, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("en_off_grant[%0d]", k), {last_pg, last_sg}, 0);
      checkOutput($sformatf("en_off_valid[%0d]", k), out_valid_o, 0);
    end
    enable_i = 1'b1;
    for (int c = 0; c < 50 && emitted.size() < 5; c++) tick();
    tick();
    checkOutput("en_len", emitted.size(), 5);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("en_pkt[%0d]", i), emittedAt(i), ent(2'd0, 32'hF000_0000 + 32'(i)));
    checkOutput("en_sw", emittedAt(4), ent(2'd1, 32'h0BAD_F00D));

    checkOutput("grant_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
